// File: rtl/doppler_nco_multi.sv
// Time-multiplexed Doppler NCO: NUM_CH channels share one phase/LUT datapath.
// Each channel keeps phase, frequency and frequency-rate accumulators. A dv_in
// strobe sweeps every channel once, one per cycle. Each sample leaves the block
// three cycles after its channel issues, tagged with the channel index.
`timescale 1ns/1ps
module doppler_nco_multi #(
    parameter int NUM_CH     = 4,
    parameter int PHASE_W    = 32,
    parameter int LUT_ADDR_W = 6,
    parameter int OUT_W      = 6,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_we,
    input  logic [CH_W-1:0]         cfg_ch,
    input  logic [1:0]              cfg_sel,
    input  logic [PHASE_W-1:0]      cfg_data,
    input  logic                    dv_in,
    output logic                    busy,
    output logic                    overrun,
    output logic                    dv_out,
    output logic [CH_W-1:0]         ch_out,
    output logic signed [OUT_W-1:0] real_out,
    output logic signed [OUT_W-1:0] imag_out
);

    localparam int IDX_W     = LUT_ADDR_W + 2;
    localparam int LUT_DEPTH = 1 << LUT_ADDR_W;
    localparam int AMP       = (1 << (OUT_W - 1)) - 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    // Quarter-wave table sampled at half-index offsets, so mirroring the
    // address (~a) and negating the value cover the other three quadrants.
    function automatic logic [LUT_DEPTH*OUT_W-1:0] build_lut();
        logic [LUT_DEPTH*OUT_W-1:0] t;
        real ang;
        int  v;
        t = '0;
        for (int unsigned i = 0; i < LUT_DEPTH; i++) begin
            ang = 2.0 * 3.14159265358979323846 * (real'(i) + 0.5) / real'(4 * LUT_DEPTH);
            v   = $rtoi(real'(AMP) * $sin(ang) + 0.5);
            t[i*OUT_W +: OUT_W] = v[OUT_W-1:0];
        end
        return t;
    endfunction

    localparam logic [LUT_DEPTH*OUT_W-1:0] LUT = build_lut();

    function automatic logic [OUT_W-1:0] lut_rd(input logic [LUT_ADDR_W-1:0] a);
        return LUT[int'(a)*OUT_W +: OUT_W];
    endfunction

    logic [0:0]         state;
    logic [CH_W-1:0]    cnt;
    logic               last;
    logic               issuing;

    logic [PHASE_W-1:0] phase_r [NUM_CH];
    logic [PHASE_W-1:0] freq_r  [NUM_CH];
    logic [PHASE_W-1:0] rate_r  [NUM_CH];

    logic [NUM_CH-1:0]  issue_sel;
    logic [NUM_CH-1:0]  wr_freq;
    logic [NUM_CH-1:0]  wr_rate;
    logic [NUM_CH-1:0]  wr_phase;

    logic               s1_valid;
    logic [CH_W-1:0]    s1_ch;
    logic [IDX_W-1:0]   s1_idx;

    logic               s2_valid;
    logic [CH_W-1:0]    s2_ch;
    logic [1:0]         s2_quad;
    logic [OUT_W-1:0]   s2_fwd;
    logic [OUT_W-1:0]   s2_rev;

    logic [OUT_W-1:0]   fold_re;
    logic [OUT_W-1:0]   fold_im;

    assign issuing = (state == ST_SWEEP);
    assign last    = (cnt == CH_W'(NUM_CH - 1));
    assign busy    = issuing;

    // Per-channel issue and config-write decode
    always_comb begin
        issue_sel = '0;
        wr_freq   = '0;
        wr_rate   = '0;
        wr_phase  = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            issue_sel[k] = issuing && (cnt == CH_W'(k));
            wr_freq[k]   = cfg_we && (cfg_sel == 2'd0) && (cfg_ch == CH_W'(k));
            wr_rate[k]   = cfg_we && (cfg_sel == 2'd1) && (cfg_ch == CH_W'(k));
            wr_phase[k]  = cfg_we && (cfg_sel == 2'd2) && (cfg_ch == CH_W'(k));
        end
    end

    // Sweep sequencer; a strobe on the last issue cycle chains a new epoch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dv_in) begin
                        state <= ST_SWEEP;
                        cnt   <= '0;
                    end
                end
                default: begin
                    if (last) begin
                        cnt <= '0;
                        if (!dv_in) state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Sticky overrun: a rejected strobe takes priority over a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (dv_in && issuing && !last) begin
            overrun <= 1'b1;
        end else if (cfg_we && (cfg_sel == 2'd3)) begin
            overrun <= 1'b0;
        end
    end

    // Channel accumulators; a config write overrides only its own register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                phase_r[k] <= '0;
                freq_r[k]  <= '0;
                rate_r[k]  <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (wr_phase[k])       phase_r[k] <= cfg_data;
                else if (issue_sel[k]) phase_r[k] <= phase_r[k] + freq_r[k];
                if (wr_freq[k])        freq_r[k]  <= cfg_data;
                else if (issue_sel[k]) freq_r[k]  <= freq_r[k] + rate_r[k];
                if (wr_rate[k])        rate_r[k]  <= cfg_data;
            end
        end
    end

    // Stage 1: capture the pre-update phase index of the issued channel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= issuing;
            s1_ch    <= cnt;
            s1_idx   <= phase_r[cnt][PHASE_W-1 -: IDX_W];
        end
    end

    // Stage 2: read forward and mirrored quarter-table entries
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_ch    <= '0;
            s2_quad  <= '0;
            s2_fwd   <= '0;
            s2_rev   <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_ch    <= s1_ch;
            s2_quad  <= s1_idx[IDX_W-1 -: 2];
            s2_fwd   <= lut_rd(s1_idx[LUT_ADDR_W-1:0]);
            s2_rev   <= lut_rd(~s1_idx[LUT_ADDR_W-1:0]);
        end
    end

    // Quadrant fold: cosine is sine advanced by one quadrant
    always_comb begin
        fold_re = s2_rev;
        fold_im = s2_fwd;
        case (s2_quad)
            2'd0: begin fold_re = s2_rev;       fold_im = s2_fwd;       end
            2'd1: begin fold_re = '0 - s2_fwd;  fold_im = s2_rev;       end
            2'd2: begin fold_re = '0 - s2_rev;  fold_im = '0 - s2_fwd;  end
            default: begin fold_re = s2_fwd;    fold_im = '0 - s2_rev;  end
        endcase
    end

    // Stage 3: output register; holds the last sample between valid cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dv_out   <= 1'b0;
            ch_out   <= '0;
            real_out <= '0;
            imag_out <= '0;
        end else begin
            dv_out <= s2_valid;
            if (s2_valid) begin
                ch_out   <= s2_ch;
                real_out <= fold_re;
                imag_out <= fold_im;
            end
        end
    end

endmodule

// File: tb/tb_doppler_nco_multi.sv
// Self-checking bench for doppler_nco_multi: an epoch/queue-level reference
// model is compared every cycle, plus literal spot values for known phases.
`timescale 1ns/1ps
module tb_doppler_nco_multi;

    localparam int  N    = 4;
    localparam int  PW   = 32;
    localparam int  LA   = 6;
    localparam int  OW   = 6;
    localparam int  CW   = 2;
    localparam int  IDXW = LA + 2;
    localparam int  AMP  = (1 << (OW - 1)) - 1;
    localparam int  REC  = 1100;
    localparam real PI   = 3.14159265358979323846;

    logic                 clk      = 1'b0;
    logic                 reset    = 1'b0;
    logic                 cfg_we   = 1'b0;
    logic [CW-1:0]        cfg_ch   = '0;
    logic [1:0]           cfg_sel  = '0;
    logic [PW-1:0]        cfg_data = '0;
    logic                 dv_in    = 1'b0;
    logic                 busy, overrun, dv_out;
    logic [CW-1:0]        ch_out;
    logic signed [OW-1:0] real_out, imag_out;

    doppler_nco_multi #(
        .NUM_CH(N), .PHASE_W(PW), .LUT_ADDR_W(LA), .OUT_W(OW)
    ) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_sel(cfg_sel), .cfg_data(cfg_data), .dv_in(dv_in),
        .busy(busy), .overrun(overrun), .dv_out(dv_out), .ch_out(ch_out),
        .real_out(real_out), .imag_out(imag_out)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct { longint at; int ch; } issue_t;
    typedef struct { longint due; int ch; int re; int im; } sample_t;

    issue_t        iss_q[$];
    sample_t       out_q[$];
    logic [PW-1:0] m_phase [N];
    logic [PW-1:0] m_freq  [N];
    logic [PW-1:0] m_rate  [N];
    longint        cyc = 0;
    bit            e_busy, e_ovr, e_dv;
    int            e_ch, e_re, e_im;

    int rec_re [N][REC];
    int rec_im [N][REC];
    int rec_cnt[N];
    int dv_seen;
    int gap;

    logic [PW-1:0] ld_ph[3] = '{32'h4000_0000, 32'h8000_0000, 32'hC000_0000};
    int            ld_re[3] = '{0, -31, 0};
    int            ld_im[3] = '{31, 0, -31};

    function automatic int ref_val(int p, bit want_cos);
        real a, x;
        a = 2.0 * PI * (real'(p) + 0.5) / real'(1 << IDXW);
        x = real'(AMP) * (want_cos ? $cos(a) : $sin(a));
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        iss_q.delete();
        out_q.delete();
        for (int k = 0; k < N; k++) begin
            m_phase[k] = '0;
            m_freq[k]  = '0;
            m_rate[k]  = '0;
        end
        e_busy = 0; e_ovr = 0; e_dv = 0;
        e_ch = 0; e_re = 0; e_im = 0;
    endtask

    task automatic model_step();
        int      k, p;
        sample_t s;
        issue_t  it;
        cyc++;
        if (iss_q.size() != 0 && iss_q[0].at == cyc) begin
            k = iss_q[0].ch;
            void'(iss_q.pop_front());
            p = int'(m_phase[k][PW-1 -: IDXW]);
            s.due = cyc + 2; s.ch = k;
            s.re = ref_val(p, 1'b1);
            s.im = ref_val(p, 1'b0);
            out_q.push_back(s);
            m_phase[k] = m_phase[k] + m_freq[k];
            m_freq[k]  = m_freq[k] + m_rate[k];
        end
        if (cfg_we) begin
            case (cfg_sel)
                2'd0:    m_freq[cfg_ch]  = cfg_data;
                2'd1:    m_rate[cfg_ch]  = cfg_data;
                2'd2:    m_phase[cfg_ch] = cfg_data;
                default: e_ovr = 1'b0;
            endcase
        end
        if (dv_in) begin
            if (iss_q.size() == 0) begin
                for (int j = 0; j < N; j++) begin
                    it.at = cyc + 1 + j;
                    it.ch = j;
                    iss_q.push_back(it);
                end
            end else begin
                e_ovr = 1'b1;
            end
        end
        e_busy = (iss_q.size() != 0);
        e_dv   = 1'b0;
        if (out_q.size() != 0 && out_q[0].due == cyc) begin
            s = out_q.pop_front();
            e_dv = 1'b1; e_ch = s.ch; e_re = s.re; e_im = s.im;
        end
    endtask

    // Compare process: advance the model at each edge, check outputs 1 ns later
    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else        model_step();
            #1;
            chk("busy",    int'(busy),     int'(e_busy));
            chk("overrun", int'(overrun),  int'(e_ovr));
            chk("dv_out",  int'(dv_out),   int'(e_dv));
            chk("ch_out",  int'(ch_out),   e_ch);
            chk("real",    int'(real_out), e_re);
            chk("imag",    int'(imag_out), e_im);
            if (dv_out) dv_seen++;
            if (e_dv && rec_cnt[e_ch] < REC) begin
                rec_re[e_ch][rec_cnt[e_ch]] = int'(real_out);
                rec_im[e_ch][rec_cnt[e_ch]] = int'(imag_out);
                rec_cnt[e_ch]++;
            end
        end
    end

    task automatic clear_rec();
        for (int k = 0; k < N; k++) rec_cnt[k] = 0;
        dv_seen = 0;
    endtask

    task automatic cfg_write(int ch, int sel, logic [PW-1:0] d);
        cfg_we = 1'b1; cfg_ch = CW'(ch); cfg_sel = 2'(sel); cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic pulse(int g);
        dv_in = 1'b1;
        @(negedge clk);
        dv_in = 1'b0;
        repeat (g - 1) @(negedge clk);
    endtask

    task automatic drain();
        repeat (N + 4) @(negedge clk);
    endtask

    task automatic pin(string name, int ch, int idx, int re, int im);
        chk({name, " re"}, rec_re[ch][idx], re);
        chk({name, " im"}, rec_im[ch][idx], im);
    endtask

    initial begin
        // reset, then one sweep from all-zero registers
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        clear_rec();
        pulse(N);
        drain();
        for (int k = 0; k < N; k++) pin($sformatf("reset ch%0d", k), k, 0, 31, 0);

        // phase loads on channel 0, value repeats every epoch
        for (int t = 0; t < 3; t++) begin
            cfg_write(0, 2, ld_ph[t]);
            clear_rec();
            pulse(N);
            pulse(N);
            drain();
            for (int e = 0; e < 2; e++) pin($sformatf("phase load %0d ep%0d", t, e), 0, e, ld_re[t], ld_im[t]);
        end

        // dv_in at E0 and E0+2: single sweep, sticky overrun until cleared
        clear_rec();
        dv_in = 1'b1; @(negedge clk);
        dv_in = 1'b0; @(negedge clk);
        dv_in = 1'b1; @(negedge clk);
        dv_in = 1'b0;
        drain();
        chk("overrun set", int'(overrun), 1);
        chk("overrun sweep samples", dv_seen, N);
        cfg_write(0, 3, '0);
        chk("overrun cleared", int'(overrun), 0);

        // freq write colliding with channel 0 issue edge
        cfg_write(0, 0, 32'h0100_0000);
        cfg_write(0, 2, '0);
        clear_rec();
        dv_in = 1'b1; @(negedge clk);
        dv_in = 1'b0;
        cfg_we = 1'b1; cfg_ch = '0; cfg_sel = 2'd0; cfg_data = 32'h0500_0000;
        @(negedge clk);
        cfg_we = 1'b0;
        drain();
        pulse(N);
        pulse(N);
        drain();
        pin("collision old step", 0, 1, 31, 1);
        pin("collision new freq", 0, 2, 31, 5);

        // long randomized run: ch1 constant freq, ch2 rate ramp, ch0/ch3 random
        cfg_write(1, 0, 32'h0100_0000); cfg_write(1, 1, '0); cfg_write(1, 2, '0);
        cfg_write(2, 0, '0); cfg_write(2, 1, 32'h0001_0000); cfg_write(2, 2, '0);
        clear_rec();
        for (int e = 0; e < 1001; e++) begin
            gap = N + $urandom_range(0, 2);
            dv_in = 1'b1;
            @(negedge clk);
            dv_in = 1'b0;
            for (int c = 1; c < gap; c++) begin
                if ($urandom_range(0, 4) == 0) begin
                    cfg_we   = 1'b1;
                    cfg_ch   = ($urandom_range(0, 1) != 0) ? CW'(3) : CW'(0);
                    cfg_sel  = 2'($urandom_range(0, 3));
                    cfg_data = $urandom();
                end
                if (c == 2 && $urandom_range(0, 7) == 0) dv_in = 1'b1;
                @(negedge clk);
                cfg_we = 1'b0;
                dv_in  = 1'b0;
            end
        end
        drain();
        pin("ch1 ep64", 1, 64, 0, 31);
        pin("ch1 ep256 wrap", 1, 256, 31, 0);
        pin("ch2 ep1000", 2, 1000, -22, -22);
        chk("model freq2 n=1001", int'(m_freq[2]), int'(32'h03E9_0000));
        chk("model phase2 n=1001", int'(m_phase[2]), int'(32'hA314_0000));

        // negative rate drives freq down through zero
        cfg_write(3, 1, 32'hFF00_0000);
        cfg_write(3, 0, 32'h0200_0000);
        cfg_write(3, 2, '0);
        clear_rec();
        repeat (7) pulse(N);
        drain();
        pin("ch3 decel ep2", 3, 2, 31, 3);
        pin("ch3 decel ep6", 3, 6, 31, -2);
        chk("model freq3 wrap", int'(m_freq[3]), int'(32'hFB00_0000));

        // reset after two of four channels have issued
        clear_rec();
        dv_in = 1'b1; @(negedge clk);
        dv_in = 1'b0; @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        chk("no samples after reset", dv_seen, 0);
        clear_rec();
        pulse(N);
        pulse(N);
        drain();
        for (int k = 0; k < N; k++) begin
            pin($sformatf("post-reset ch%0d ep0", k), k, 0, 31, 0);
            pin($sformatf("post-reset ch%0d ep1", k), k, 1, 31, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
